// File: rtl/sid_bus_pkg.sv
// Shared definitions for the SID register-bus write path: sequencer states,
// bus bit positions and the SID register map.
package sid_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_e;

    localparam int         STROBE_BIT = 7;
    localparam logic [1:0] VOICE_FILT = 2'd3;

    // Per-voice registers (voice 0..2)
    localparam logic [2:0] FREQ_LO = 3'd0;
    localparam logic [2:0] FREQ_HI = 3'd1;
    localparam logic [2:0] PW_LO   = 3'd2;
    localparam logic [2:0] PW_HI   = 3'd3;
    localparam logic [2:0] ATT_DEC = 3'd4;
    localparam logic [2:0] SUS_REL = 3'd5;
    localparam logic [2:0] WAV     = 3'd6;

    // Filter bank registers (voice select = VOICE_FILT)
    localparam logic [2:0] FC_LO    = 3'd0;
    localparam logic [2:0] FC_HI    = 3'd1;
    localparam logic [2:0] RES_FILT = 3'd2;
    localparam logic [2:0] MODE_VOL = 3'd3;

    function automatic logic [7:0] make_ctrl(input logic strobe,
                                             input logic [1:0] voice,
                                             input logic [2:0] addr);
        logic [7:0] ctrl;
        ctrl             = {3'b000, voice, addr};
        ctrl[STROBE_BIT] = strobe;
        return ctrl;
    endfunction

endpackage

// File: rtl/sid_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after the pointer;
// the pointer moves past the winner whenever advance is asserted.
module sid_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req,
    input  logic                                            advance,
    output logic [NUM_REQ-1:0]                              grant,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_idx,
    output logic                                            any_req
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDW-1:0] ptr;
    int             cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        cand      = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (!any_req && req[cand]) begin
                any_req     = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDW'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/sid_write_sequencer.sv
// Arbitrates requester writes and serialises them onto the tt_um_sid register
// bus with registered setup / strobe / hold timing.
module sid_write_sequencer
    import sid_bus_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [NUM_REQ-1:0]                              req_valid,
    output logic [NUM_REQ-1:0]                              req_ready,
    input  logic [2*NUM_REQ-1:0]                            req_voice,
    input  logic [3*NUM_REQ-1:0]                            req_addr,
    input  logic [8*NUM_REQ-1:0]                            req_data,
    output logic [7:0]                                      bus_ctrl,
    output logic [7:0]                                      bus_data,
    output logic                                            busy,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                            done
);

    localparam int IDW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int MAXSC = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAXC  = (MAXSC > HOLD_CYCLES) ? MAXSC : HOLD_CYCLES;
    localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

    seq_state_e     state, state_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0] win_idx;
    logic           any_valid;
    logic           handshake;
    logic [1:0]     lat_voice, pay_voice;
    logic [2:0]     lat_addr, pay_addr;
    logic [7:0]     lat_data, pay_data;
    logic [7:0]     ctrl_d, data_d;
    logic           done_d;

    sid_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (handshake),
        .grant     (grant),
        .grant_idx (win_idx),
        .any_req   (any_valid)
    );

    assign handshake = (state == ST_IDLE) && any_valid;
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    state_next = ST_SETUP;
                    cnt_next   = CW'(SETUP_CYCLES - 1);
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = ST_STROBE;
                    cnt_next   = CW'(STROBE_CYCLES - 1);
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_STROBE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Bus registers are loaded from the next state so the strobe comes straight off a flop.
    always_comb begin
        pay_voice = lat_voice;
        pay_addr  = lat_addr;
        pay_data  = lat_data;
        if (handshake) begin
            pay_voice = req_voice[int'(win_idx) * 2 +: 2];
            pay_addr  = req_addr[int'(win_idx) * 3 +: 3];
            pay_data  = req_data[int'(win_idx) * 8 +: 8];
        end
        ctrl_d = '0;
        data_d = '0;
        if (state_next != ST_IDLE) begin
            ctrl_d = make_ctrl(state_next == ST_STROBE, pay_voice, pay_addr);
            data_d = pay_data;
        end
        done_d = (state_next == ST_HOLD) && (cnt_next == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_voice <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            grant_id  <= '0;
            bus_ctrl  <= '0;
            bus_data  <= '0;
            done      <= 1'b0;
        end else begin
            lat_voice <= pay_voice;
            lat_addr  <= pay_addr;
            lat_data  <= pay_data;
            if (handshake) begin
                grant_id <= win_idx;
            end
            bus_ctrl <= ctrl_d;
            bus_data <= data_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_sid_write_sequencer.sv
// Directed self-checking bench for sid_write_sequencer: default timing DUT plus
// a second instance with stretched setup/strobe/hold timing.
module tb_sid_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;

    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_voice;
    logic [5:0]  req_addr;
    logic [15:0] req_data;
    logic [7:0]  bus_ctrl, bus_data;
    logic        busy, done;
    logic [0:0]  grant_id;

    logic [1:0]  b_valid;
    logic [1:0]  b_ready;
    logic [3:0]  b_voice;
    logic [5:0]  b_addr;
    logic [15:0] b_data;
    logic [7:0]  b_ctrl, b_bdata;
    logic        b_busy, b_done;
    logic [0:0]  b_grant;

    int cmp_count  = 0;
    int fail_count = 0;
    int cycle      = 0;

    logic        prev_strobe;
    logic [15:0] wr_log[$];

    // Voice 0: 440 Hz sawtooth, filter: LP, fc_hi 0x20, volume 15; packed {voice, addr, data}
    logic [12:0] stim6 [8] = '{
        {2'd0, 3'd0, 8'hD6}, {2'd0, 3'd1, 8'h1C}, {2'd0, 3'd4, 8'h09}, {2'd0, 3'd5, 8'hF0},
        {2'd3, 3'd1, 8'h20}, {2'd3, 3'd2, 8'h01}, {2'd3, 3'd3, 8'h1F}, {2'd0, 3'd6, 8'h21}
    };
    logic [15:0] exp6 [8] = '{
        16'h80D6, 16'h811C, 16'h8409, 16'h85F0, 16'h9920, 16'h9A01, 16'h9B1F, 16'h8621
    };

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    sid_write_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_voice (req_voice),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .bus_ctrl  (bus_ctrl),
        .bus_data  (bus_data),
        .busy      (busy),
        .grant_id  (grant_id),
        .done      (done)
    );

    sid_write_sequencer #(
        .NUM_REQ       (2),
        .SETUP_CYCLES  (2),
        .STROBE_CYCLES (3),
        .HOLD_CYCLES   (2)
    ) u_dut_slow (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_valid),
        .req_ready (b_ready),
        .req_voice (b_voice),
        .req_addr  (b_addr),
        .req_data  (b_data),
        .bus_ctrl  (b_ctrl),
        .bus_data  (b_bdata),
        .busy      (b_busy),
        .grant_id  (b_grant),
        .done      (b_done)
    );

    // Captures every register write as seen by the SID at the strobe rising edge
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            prev_strobe <= 1'b0;
        end else begin
            if (bus_ctrl[7] && !prev_strobe) wr_log.push_back({bus_ctrl, bus_data});
            prev_strobe <= bus_ctrl[7];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [1:0] v, input logic [2:0] a,
                                 input logic [7:0] d);
        req_voice[2*idx +: 2] = v;
        req_addr[3*idx +: 3]  = a;
        req_data[8*idx +: 8]  = d;
        req_valid[idx]        = 1'b1;
    endtask

    task automatic doWrite(input int idx, input logic [1:0] v, input logic [2:0] a,
                           input logic [7:0] d);
        int n;
        n = 0;
        applyStimulus(idx, v, a, d);
        #1;
        while (!req_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput($sformatf("t6_handshake_r%0d", idx), 32'(n < 20), 1);
        @(negedge clk);
        req_valid[idx] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout required end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen, last, bad, run, dones, done_seen;

        rst       = 1'b1;
        req_valid = '0;
        req_voice = '0;
        req_addr  = '0;
        req_data  = '0;
        b_valid   = '0;
        b_voice   = '0;
        b_addr    = '0;
        b_data    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_ctrl",  32'(bus_ctrl),  'h00);
        checkOutput("rst_data",  32'(bus_data),  'h00);
        checkOutput("rst_busy",  32'(busy),      0);
        checkOutput("rst_grant", 32'(grant_id),  0);
        checkOutput("rst_done",  32'(done),      0);
        checkOutput("rst_ready", 32'(req_ready), 0);

        $display("[TB] test 1: single write");
        applyStimulus(0, 2'd0, 3'd0, 8'h24);
        #1 checkOutput("t1_ready", 32'(req_ready), 'b01);
        @(negedge clk);
        req_valid[0] = 1'b0;
        checkOutput("t1_setup_ctrl", 32'(bus_ctrl),  'h00);
        checkOutput("t1_setup_data", 32'(bus_data),  'h24);
        checkOutput("t1_busy",       32'(busy),      1);
        checkOutput("t1_ready_busy", 32'(req_ready), 0);
        @(negedge clk);
        checkOutput("t1_strobe1", 32'(bus_ctrl), 'h80);
        @(negedge clk);
        checkOutput("t1_strobe2", 32'(bus_ctrl), 'h80);
        checkOutput("t1_nodone",  32'(done),     0);
        @(negedge clk);
        checkOutput("t1_hold_ctrl", 32'(bus_ctrl), 'h00);
        checkOutput("t1_hold_data", 32'(bus_data), 'h24);
        checkOutput("t1_done",      32'(done),     1);
        @(negedge clk);
        checkOutput("t1_idle_busy", 32'(busy),     0);
        checkOutput("t1_idle_done", 32'(done),     0);
        checkOutput("t1_idle_data", 32'(bus_data), 'h00);

        $display("[TB] test 2: filter write");
        applyStimulus(1, 2'd3, 3'd3, 8'h1F);
        #1 checkOutput("t2_ready", 32'(req_ready), 'b10);
        @(negedge clk);
        req_valid[1] = 1'b0;
        checkOutput("t2_setup_ctrl", 32'(bus_ctrl), 'h1B);
        checkOutput("t2_setup_data", 32'(bus_data), 'h1F);
        checkOutput("t2_grant",      32'(grant_id), 1);
        @(negedge clk);
        checkOutput("t2_strobe1", 32'(bus_ctrl), 'h9B);
        @(negedge clk);
        checkOutput("t2_strobe2", 32'(bus_ctrl), 'h9B);
        @(negedge clk);
        checkOutput("t2_hold_ctrl", 32'(bus_ctrl), 'h1B);
        checkOutput("t2_hold_data", 32'(bus_data), 'h1F);
        checkOutput("t2_done",      32'(done),     1);
        @(negedge clk);

        $display("[TB] test 3: continuous contention");
        applyStimulus(0, 2'd0, 3'd5, 8'hA0);
        applyStimulus(1, 2'd1, 3'd2, 8'h5B);
        seen = 0;
        last = 0;
        bad  = 0;
        for (int k = 0; k < 60 && seen < 6; k++) begin
            @(negedge clk);
            if (req_ready == 2'b11) bad++;
            if (done) begin
                checkOutput($sformatf("t3_grant%0d", seen), 32'(grant_id), 32'(seen % 2));
                if (seen > 0) checkOutput($sformatf("t3_spacing%0d", seen), cycle - last, 5);
                last = cycle;
                seen++;
                if (seen == 6) req_valid = '0;
            end
        end
        req_valid = '0;
        checkOutput("t3_count",  seen, 6);
        checkOutput("t3_onehot", bad,  0);
        @(negedge clk);

        $display("[TB] test 4: reset mid-strobe");
        applyStimulus(0, 2'd0, 3'd4, 8'h77);
        @(negedge clk);
        req_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_strobe", 32'(bus_ctrl), 'h84);
        rst = 1'b1;
        #1;
        checkOutput("t4_rst_ctrl", 32'(bus_ctrl), 'h00);
        checkOutput("t4_rst_busy", 32'(busy),     0);
        checkOutput("t4_rst_done", 32'(done),     0);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checkOutput("t4_no_done", done_seen, 0);
        applyStimulus(0, 2'd2, 3'd0, 8'h11);
        applyStimulus(1, 2'd1, 3'd1, 8'h22);
        #1 checkOutput("t4_ready_after", 32'(req_ready), 'b01);
        @(negedge clk);
        req_valid = '0;
        checkOutput("t4_grant_after", 32'(grant_id), 0);
        checkOutput("t4_ctrl_after",  32'(bus_ctrl), 'h10);
        repeat (4) @(negedge clk);
        checkOutput("t4_idle_again", 32'(busy), 0);

        $display("[TB] test 5: stretched timing");
        b_voice[1:0] = 2'd2;
        b_addr[2:0]  = 3'd1;
        b_data[7:0]  = 8'h3C;
        b_valid[0]   = 1'b1;
        run   = 0;
        bad   = 0;
        dones = 0;
        last  = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (b_busy && b_ready != 2'b00) bad++;
            if (b_ctrl[7]) begin
                run++;
                if (run == 1) checkOutput("t5_ctrl", 32'(b_ctrl), 'h91);
            end else if (run > 0) begin
                checkOutput("t5_strobe_len", run, 3);
                run = 0;
            end
            if (b_done) begin
                if (dones > 0) checkOutput("t5_period", cycle - last, 8);
                last = cycle;
                dones++;
            end
        end
        b_valid = '0;
        checkOutput("t5_dones",        32'(dones >= 4), 1);
        checkOutput("t5_ready_nonidle", bad, 0);
        repeat (10) @(negedge clk);

        $display("[TB] test 6: register sequence through requester 1");
        wr_log.delete();
        for (int i = 0; i < 8; i++) begin
            doWrite(1, stim6[i][12:11], stim6[i][10:8], stim6[i][7:0]);
        end
        checkOutput("t6_count", wr_log.size(), 8);
        for (int i = 0; i < 8 && i < wr_log.size(); i++) begin
            checkOutput($sformatf("t6_write%0d", i), 32'(wr_log[i]), 32'(exp6[i]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
        $finish;
    end

endmodule
